// File: rtl/hprb_multi_source_pkg.sv
// Shared definitions for the multi-destination probe source: default field widths,
// FSM state encoding, payload modes, LFSR tap table and the redundancy function.
package hprb_multi_source_pkg;

  localparam int NS_ADDRESS_SIZE = 6;
  localparam int NS_DATA_SIZE    = 16;
  localparam int NS_REDUN_SIZE   = 4;
  localparam int NS_ACK_CKS      = 2;

  localparam int DAT_COUNTER = 0;
  localparam int DAT_LFSR    = 1;
  localparam int DAT_CONST   = 2;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_LD_DST,
    ST_LD_DAT,
    ST_LD_RED,
    ST_REQ,
    ST_ACK_LO,
    ST_GAP,
    ST_DONE
  } state_e;

  // Right-shifting Galois masks for maximal-length polynomials; unknown widths fall
  // back to a pure rotate, which still never reaches zero from a nonzero seed.
  function automatic logic [63:0] lfsr_taps(input int w);
    logic [63:0] taps;
    case (w)
      2:       taps = 64'h3;
      3:       taps = 64'h6;
      4:       taps = 64'hC;
      5:       taps = 64'h14;
      6:       taps = 64'h30;
      7:       taps = 64'h60;
      8:       taps = 64'hB8;
      9:       taps = 64'h110;
      10:      taps = 64'h240;
      11:      taps = 64'h500;
      12:      taps = 64'hE08;
      16:      taps = 64'hB400;
      24:      taps = 64'hE10000;
      32:      taps = 64'h8020_0003;
      64:      taps = 64'hD800_0000_0000_0000;
      default: taps = 64'h1 << (w - 1);
    endcase
    return taps;
  endfunction

  // Redundancy: XOR-fold of {src, dst, dat} into rsz-bit chunks, lsb-aligned.
  function automatic logic [63:0] calc_redun(input logic [63:0] src, input logic [63:0] dst,
                                             input logic [63:0] dat, input int asz,
                                             input int dsz, input int rsz);
    logic [191:0] cat;
    logic [63:0]  r;
    cat = ({128'd0, src} << (asz + dsz)) | ({128'd0, dst} << dsz) | {128'd0, dat};
    r   = '0;
    for (int i = 0; i < 2 * asz + dsz; i++) begin
      r[i % rsz] = r[i % rsz] ^ cat[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/hprb_multi_source_pattern_gen.sv
// Payload pattern source: counter, Galois LFSR or constant; pat_o is the value the
// next loaded message will carry, and it steps only when adv_i is pulsed.
module hprb_multi_source_pattern_gen import hprb_multi_source_pkg::*; #(
  parameter int          DAT_MODE = DAT_COUNTER,
  parameter int unsigned DAT_SEED = 0,
  parameter int          DSZ      = NS_DATA_SIZE
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           adv_i,
  output logic [DSZ-1:0] pat_o
);

  localparam logic [63:0]    TAPS_FULL = lfsr_taps(DSZ);
  localparam logic [DSZ-1:0] TAPS      = TAPS_FULL[DSZ-1:0];
  localparam logic [DSZ-1:0] SEED      = DSZ'(DAT_SEED);
  // An all-zero LFSR would lock up, so a zero seed starts the LFSR at 1.
  localparam logic [DSZ-1:0] INIT_PAT  = (DAT_MODE == DAT_LFSR && SEED == '0) ? DSZ'(1) : SEED;

  logic [DSZ-1:0] pat_q, pat_d;

  always_comb begin
    pat_d = pat_q;
    if (adv_i) begin
      case (DAT_MODE)
        DAT_COUNTER: pat_d = pat_q + DSZ'(1);
        DAT_LFSR:    pat_d = (pat_q >> 1) ^ (pat_q[0] ? TAPS : '0);
        DAT_CONST:   pat_d = pat_q;
        default:     pat_d = pat_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pat_q <= INIT_PAT;
    else         pat_q <= pat_d;
  end

  assign pat_o = pat_q;

endmodule

// File: rtl/hprb_multi_source.sv
// Probe traffic generator: sends NUM_MSGS (or endless) 4-phase messages round-robin
// over NUM_DST destinations, with an optional idle gap after every handshake.
module hprb_multi_source import hprb_multi_source_pkg::*; #(
  parameter int unsigned MY_LOCAL_ADDR = 0,
  parameter int unsigned DST_BASE      = 0,
  parameter int unsigned DST_STRIDE    = 1,
  parameter int          NUM_DST       = 1,
  parameter int unsigned NUM_MSGS      = 0,
  parameter int          DAT_MODE      = DAT_COUNTER,
  parameter int unsigned DAT_SEED      = 0,
  parameter int          GAP_CKS       = 0,
  parameter int          CSZ           = 16,
  parameter int          ASZ           = NS_ADDRESS_SIZE,
  parameter int          DSZ           = NS_DATA_SIZE,
  parameter int          RSZ           = NS_REDUN_SIZE,
  parameter int          SND_ACK_CKS   = NS_ACK_CKS
) (
  input  logic           gch_clk,
  input  logic           gch_reset,
  output logic           gch_ready,
  input  logic           en,
  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic           snd0_err,
  output logic           snd0_req_out,
  input  logic           snd0_ack_in,
  output logic           done,
  output logic [CSZ-1:0] sent_cnt
);

  localparam int IDXW = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
  localparam int GAPW = (GAP_CKS > 1) ? $clog2(GAP_CKS) : 1;
  localparam int ACKW = $clog2(SND_ACK_CKS + 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_DST - 1);
  localparam logic [GAPW-1:0] GAP_LAST   = GAPW'(GAP_CKS - 1);
  localparam logic [ACKW-1:0] ACK_LAST   = ACKW'(SND_ACK_CKS - 1);
  localparam logic [CSZ:0]    MSG_TARGET = (CSZ + 1)'(NUM_MSGS);
  localparam logic [ASZ-1:0]  SRC_ADDR   = ASZ'(MY_LOCAL_ADDR);

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic            rg_rdy_q, rg_rdy_d;
  logic [CSZ-1:0]  sent_q, sent_d;
  logic [CSZ:0]    msg_q, msg_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [GAPW-1:0] gap_q, gap_d;
  logic [ASZ-1:0]  dst_q, dst_d;
  logic [DSZ-1:0]  dat_q, dat_d;
  logic [RSZ-1:0]  red_q, red_d;
  logic [ACKW-1:0] ack_cnt_q, ack_cnt_d;
  logic            ckd_ack_q, ckd_ack_d;
  logic            pat_adv;
  logic            last_msg;
  logic [DSZ-1:0]  pat;

  hprb_multi_source_pattern_gen #(
    .DAT_MODE(DAT_MODE),
    .DAT_SEED(DAT_SEED),
    .DSZ     (DSZ)
  ) u_pattern (
    .clk_i (gch_clk),
    .rst_ni(gch_reset),
    .adv_i (pat_adv),
    .pat_o (pat)
  );

  // The raw ack must disagree with the debounced copy for SND_ACK_CKS straight clocks.
  always_comb begin
    ckd_ack_d = ckd_ack_q;
    ack_cnt_d = '0;
    if (snd0_ack_in != ckd_ack_q) begin
      if (ack_cnt_q == ACK_LAST) ckd_ack_d = snd0_ack_in;
      else                       ack_cnt_d = ack_cnt_q + ACKW'(1);
    end
  end

  assign last_msg = (NUM_MSGS != 0) && (msg_q == MSG_TARGET);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    done_d   = done_q;
    rg_rdy_d = rg_rdy_q;
    sent_d   = sent_q;
    msg_d    = msg_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    dst_d    = dst_q;
    dat_d    = dat_q;
    red_d    = red_q;
    pat_adv  = 1'b0;
    case (state_q)
      ST_INIT: begin
        rg_rdy_d = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_IDLE: if (en && !ckd_ack_q) state_d = ST_LD_DST;
      ST_LD_DST: begin
        dst_d   = ASZ'(DST_BASE + 32'(idx_q) * DST_STRIDE);
        state_d = ST_LD_DAT;
      end
      ST_LD_DAT: begin
        dat_d   = pat;
        pat_adv = 1'b1;
        state_d = ST_LD_RED;
      end
      ST_LD_RED: begin
        red_d   = RSZ'(calc_redun(64'(SRC_ADDR), 64'(dst_q), 64'(dat_q), ASZ, DSZ, RSZ));
        req_d   = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ: if (ckd_ack_q) begin
        req_d   = 1'b0;
        sent_d  = sent_q + CSZ'(1);
        msg_d   = msg_q + (CSZ + 1)'(1);
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
        state_d = ST_ACK_LO;
      end
      ST_ACK_LO: if (!ckd_ack_q) begin
        gap_d = '0;
        if (GAP_CKS > 0) begin
          state_d = ST_GAP;
        end else if (last_msg) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + GAPW'(1);
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (last_msg) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: req_d = 1'b0;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      state_q   <= ST_INIT;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      rg_rdy_q  <= 1'b0;
      sent_q    <= '0;
      msg_q     <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      dst_q     <= ASZ'(DST_BASE);
      dat_q     <= '0;
      red_q     <= '0;
      ack_cnt_q <= '0;
      ckd_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      done_q    <= done_d;
      rg_rdy_q  <= rg_rdy_d;
      sent_q    <= sent_d;
      msg_q     <= msg_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      dst_q     <= dst_d;
      dat_q     <= dat_d;
      red_q     <= red_d;
      ack_cnt_q <= ack_cnt_d;
      ckd_ack_q <= ckd_ack_d;
    end
  end

  assign gch_ready    = rg_rdy_q && (ack_cnt_q == '0);
  assign snd0_src     = SRC_ADDR;
  assign snd0_dst     = dst_q;
  assign snd0_dat     = dat_q;
  assign snd0_red     = red_q;
  assign snd0_err     = 1'b0;
  assign snd0_req_out = req_q;
  assign done         = done_q;
  assign sent_cnt     = sent_q;

endmodule

// File: tb/tb_hprb_multi_source.sv
// Bench for hprb_multi_source: a finite counter-mode instance checked from a vector
// table, and a free-running LFSR instance with random ack timing against a model.
module tb_hprb_multi_source;

  localparam int ASZ  = 6;
  localparam int DSZ  = 8;
  localparam int RSZ  = 4;
  localparam int CSZ  = 16;
  localparam int ACKC = 2;
  localparam int GAPB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;
  logic enA, ackA, readyA, reqA, errA, doneA;
  logic [ASZ-1:0] srcA, dstA;
  logic [DSZ-1:0] datA;
  logic [RSZ-1:0] redA;
  logic [CSZ-1:0] sentA;
  logic enB, ackB, readyB, reqB, errB, doneB;
  logic [ASZ-1:0] srcB, dstB;
  logic [DSZ-1:0] datB;
  logic [RSZ-1:0] redB;
  logic [CSZ-1:0] sentB;

  int checks = 0;
  int errors = 0;

  hprb_multi_source #(
    .MY_LOCAL_ADDR(5), .DST_BASE(4), .DST_STRIDE(2), .NUM_DST(3), .NUM_MSGS(6),
    .DAT_MODE(0), .DAT_SEED(0), .GAP_CKS(0), .CSZ(CSZ), .ASZ(ASZ), .DSZ(DSZ),
    .RSZ(RSZ), .SND_ACK_CKS(ACKC)
  ) dutA (
    .gch_clk(clk), .gch_reset(rstN), .gch_ready(readyA), .en(enA),
    .snd0_src(srcA), .snd0_dst(dstA), .snd0_dat(datA), .snd0_red(redA),
    .snd0_err(errA), .snd0_req_out(reqA), .snd0_ack_in(ackA),
    .done(doneA), .sent_cnt(sentA)
  );

  hprb_multi_source #(
    .MY_LOCAL_ADDR(9), .DST_BASE(62), .DST_STRIDE(3), .NUM_DST(2), .NUM_MSGS(0),
    .DAT_MODE(1), .DAT_SEED(0), .GAP_CKS(GAPB), .CSZ(CSZ), .ASZ(ASZ), .DSZ(DSZ),
    .RSZ(RSZ), .SND_ACK_CKS(ACKC)
  ) dutB (
    .gch_clk(clk), .gch_reset(rstN), .gch_ready(readyB), .en(enB),
    .snd0_src(srcB), .snd0_dst(dstB), .snd0_dat(datB), .snd0_red(redB),
    .snd0_err(errB), .snd0_req_out(reqB), .snd0_ack_in(ackB),
    .done(doneB), .sent_cnt(sentB)
  );

  // Instance A's receiver simply echoes the request back as the acknowledge.
  always @(negedge clk) ackA = reqA;

  typedef struct {
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
  } vecA_t;
  vecA_t tblA [6];

  logic [DSZ-1:0] lfsrM;
  int             kB;
  int             sentM;
  logic [DSZ-1:0] datLog [$];

  function automatic logic [RSZ-1:0] refRedun(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                              input logic [DSZ-1:0] x);
    logic [2*ASZ+DSZ-1:0] c;
    logic [RSZ-1:0] r;
    c = {s, d, x};
    r = '0;
    for (int i = 0; i < 2 * ASZ + DSZ; i++) r[i % RSZ] = r[i % RSZ] ^ c[i];
    return r;
  endfunction

  // Galois LFSR for x^8+x^6+x^5+x^4+1.
  function automatic logic [DSZ-1:0] lfsrStep(input logic [DSZ-1:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitReqB(input logic lvl, input int budget, input string name, output int n);
    n = 0;
    while (reqB !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(reqB), 64'(lvl));
  endtask

  task automatic expectB(input string tag, output logic [DSZ-1:0] expDat);
    logic [ASZ-1:0] d;
    d      = ASZ'(62 + (kB % 2) * 3);
    expDat = lfsrM;
    checkOutput({tag, " dst"}, 64'(dstB), 64'(d));
    checkOutput({tag, " dat"}, 64'(datB), 64'(lfsrM));
    checkOutput({tag, " src"}, 64'(srcB), 64'd9);
    checkOutput({tag, " red"}, 64'(redB), 64'(refRedun(6'd9, d, lfsrM)));
    lfsrM = lfsrStep(lfsrM);
    kB++;
  endtask

  task automatic applyStimulus(input logic ackV, input int cycles);
    ackB = ackV;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic prevA, moved, flag;
    logic [ASZ-1:0] hs, hd;
    logic [DSZ-1:0] hx, expDat;
    int k, n, zeros;
    int seen [logic [DSZ-1:0]];

    tblA[0] = '{dst: 6'd4, dat: 8'd0};
    tblA[1] = '{dst: 6'd6, dat: 8'd1};
    tblA[2] = '{dst: 6'd8, dat: 8'd2};
    tblA[3] = '{dst: 6'd4, dat: 8'd3};
    tblA[4] = '{dst: 6'd6, dat: 8'd4};
    tblA[5] = '{dst: 6'd8, dat: 8'd5};

    rstN = 1'b0; enA = 1'b0; enB = 1'b0; ackB = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst reqA", 64'(reqA), 64'd0);
    checkOutput("rst doneA", 64'(doneA), 64'd0);
    checkOutput("rst sentA", 64'(sentA), 64'd0);
    checkOutput("rst readyA", 64'(readyA), 64'd0);
    checkOutput("rst dstA", 64'(dstA), 64'd4);
    checkOutput("rst datA", 64'(datA), 64'd0);
    checkOutput("rst redA", 64'(redA), 64'd0);
    checkOutput("rst srcA", 64'(srcA), 64'd5);
    checkOutput("rst errA", 64'(errA), 64'd0);
    checkOutput("rst reqB", 64'(reqB), 64'd0);
    checkOutput("rst dstB", 64'(dstB), 64'd62);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("readyA after init", 64'(readyA), 64'd1);
    checkOutput("readyB after init", 64'(readyB), 64'd1);

    // Instance A: six messages round-robin over 4,6,8 then sticky done.
    enA = 1'b1; k = 0; prevA = 1'b0; moved = 1'b0; hs = '0; hd = '0; hx = '0;
    for (int c = 0; c < 400 && !doneA; c++) begin
      @(negedge clk);
      if (reqA && !prevA) begin
        if (k < 6) begin
          checkOutput($sformatf("A msg%0d dst", k), 64'(dstA), 64'(tblA[k].dst));
          checkOutput($sformatf("A msg%0d dat", k), 64'(datA), 64'(tblA[k].dat));
          checkOutput($sformatf("A msg%0d red", k), 64'(redA),
                      64'(refRedun(6'd5, tblA[k].dst, tblA[k].dat)));
        end
        hs = srcA; hd = dstA; hx = datA; k++;
      end else if (reqA && (srcA !== hs || dstA !== hd || datA !== hx)) begin
        moved = 1'b1;
      end
      prevA = reqA;
    end
    checkOutput("A done", 64'(doneA), 64'd1);
    checkOutput("A messages", 64'(k), 64'd6);
    checkOutput("A sent_cnt", 64'(sentA), 64'd6);
    checkOutput("A fields stable under req", 64'(moved), 64'd0);
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (reqA) flag = 1'b1;
    end
    checkOutput("A quiet after done", 64'(flag), 64'd0);
    checkOutput("A done sticky", 64'(doneA), 64'd1);
    checkOutput("A sent after done", 64'(sentA), 64'd6);

    // Instance B: request rises on the 4th clock after enable is seen in IDLE.
    lfsrM = 8'd1; kB = 0; sentM = 0;
    enB = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("B req before 4th clock", 64'(reqB), 64'd0);
    @(negedge clk);
    checkOutput("B req on 4th clock", 64'(reqB), 64'd1);

    for (int m = 0; m < 256; m++) begin
      if (m > 0) begin
        waitReqB(1'b1, 40, "B req rise", n);
        checkOutput("B gap lower bound", 64'(n >= ACKC + GAPB + 4), 64'd1);
        checkOutput("B gap upper bound", 64'(n <= ACKC + GAPB + 8), 64'd1);
      end
      expectB("B rand", expDat);
      datLog.push_back(datB);
      flag = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        if (datB !== expDat || reqB !== 1'b1) flag = 1'b1;
      end
      checkOutput("B hold before ack", 64'(flag), 64'd0);
      ackB = 1'b1;
      waitReqB(1'b0, 20, "B req fall", n);
      sentM++;
      checkOutput("B sent_cnt", 64'(sentB), 64'(sentM));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ackB = 1'b0;
    end

    zeros = 0;
    for (int i = 0; i < 255; i++) begin
      if (datLog[i] == '0) zeros++;
      seen[datLog[i]] = 1;
    end
    checkOutput("B lfsr never zero", 64'(zeros), 64'd0);
    checkOutput("B lfsr 255 distinct", 64'(seen.num()), 64'd255);
    checkOutput("B lfsr period 255", 64'(datLog[255]), 64'd1);

    // Ack held high long after req drops must not let a new request start.
    waitReqB(1'b1, 40, "B hold req rise", n);
    expectB("B hold", expDat);
    ackB = 1'b1;
    waitReqB(1'b0, 20, "B hold req fall", n);
    sentM++;
    checkOutput("B hold sent_cnt", 64'(sentB), 64'(sentM));
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (reqB) flag = 1'b1;
    end
    ackB = 1'b0;
    repeat (ACKC) begin
      @(negedge clk);
      if (reqB) flag = 1'b1;
    end
    checkOutput("B no req while ack high", 64'(flag), 64'd0);

    // Dropping en mid-handshake lets the message finish, then the source waits.
    waitReqB(1'b1, 40, "B en req rise", n);
    expectB("B en", expDat);
    enB = 1'b0;
    @(negedge clk);
    checkOutput("B req held after en drop", 64'(reqB), 64'd1);
    ackB = 1'b1;
    waitReqB(1'b0, 20, "B en req fall", n);
    sentM++;
    checkOutput("B en sent_cnt", 64'(sentB), 64'(sentM));
    flag = 1'b0;
    applyStimulus(1'b0, 0);
    repeat (40) begin
      @(negedge clk);
      if (reqB) flag = 1'b1;
    end
    checkOutput("B idle while en low", 64'(flag), 64'd0);
    enB = 1'b1;
    waitReqB(1'b1, 40, "B resume req rise", n);
    expectB("B resume", expDat);

    // Reset with req high: req drops at once and the payload restarts at the seed.
    rstN = 1'b0;
    #1;
    checkOutput("B req cleared by reset", 64'(reqB), 64'd0);
    checkOutput("B sent cleared by reset", 64'(sentB), 64'd0);
    checkOutput("A done cleared by reset", 64'(doneA), 64'd0);
    checkOutput("A sent cleared by reset", 64'(sentA), 64'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    lfsrM = 8'd1; kB = 0;
    waitReqB(1'b1, 40, "B req after reset", n);
    expectB("B after reset", expDat);
    applyStimulus(1'b1, 0);
    waitReqB(1'b0, 20, "B after reset req fall", n);
    checkOutput("B sent after reset", 64'(sentB), 64'd1);
    applyStimulus(1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
